p_cacheline_adaptor: RTL and testbench

Responder for the 256-bit line interface driven by the pipelined caches: it accepts one line read or line write at a time and converts it into a four-beat, 64-bit burst transaction on main memory. It sits between a cache's `pmem_*` port and the physical memory model, absorbing the width mismatch and the multi-cycle burst so the cache sees a single `pmem_resp` pulse per line.

---
 rtl/p_cacheline_adaptor_if.sv | 31 +++
 rtl/p_cacheline_adaptor.sv | 106 ++++++++++
 tb/tb_p_cacheline_adaptor.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/p_cacheline_adaptor_if.sv
// Line-side (cache) and burst-side (memory) signals of the cacheline adaptor.
// The adaptor connects through the slave modport; the environment uses master.
interface p_cacheline_adaptor_if #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
);
  localparam int s_line = 8 * (2 ** s_offset);

  logic [s_line-1:0] line_i;
  logic [s_line-1:0] line_o;
  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [s_beat-1:0] burst_i;
  logic [s_beat-1:0] burst_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/p_cacheline_adaptor.sv
// Converts one 256-bit cache line read/write into a four-beat 64-bit memory
// burst, returning a single resp_o pulse per line.
//
// state    | meaning
// IDLE     | waiting for read_i/write_i (read wins)
// RD_BURST | collecting read beats into line_o
// WR_BURST | presenting write-buffer beats on burst_o
// DONE     | one-cycle resp_o pulse, requests ignored
module p_cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
) (
  input logic                clk,
  input logic                rst,
  p_cacheline_adaptor_if.slave bus
);
  localparam int s_line  = 8 * (2 ** s_offset);
  localparam int n_beats = s_line / s_beat;
  localparam int cw      = $clog2(n_beats);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [cw-1:0]                   cnt;
  logic [n_beats-1:0][s_beat-1:0]  wbuf;
  logic [n_beats-1:0][s_beat-1:0]  line_q;
  logic [31:0]                     addr_q;
  logic                            last_beat;

  assign last_beat = (cnt == cw'(n_beats - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.read_i)       state_nx = RD_BURST;
        else if (bus.write_i) state_nx = WR_BURST;
      end
      RD_BURST: if (bus.resp_i && last_beat) state_nx = DONE;
      WR_BURST: if (bus.resp_i && last_beat) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only, so resp_i never reaches them combinationally.
  always_comb begin
    bus.read_o  = 1'b0;
    bus.write_o = 1'b0;
    bus.resp_o  = 1'b0;
    bus.burst_o = '0;
    case (state)
      RD_BURST: bus.read_o = 1'b1;
      WR_BURST: begin
        bus.write_o = 1'b1;
        bus.burst_o = wbuf[cnt];
      end
      DONE:     bus.resp_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
      wbuf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read_i || bus.write_i) begin
            cnt    <= '0;
            addr_q <= {bus.address_i[31:s_offset], {s_offset{1'b0}}};
            if (!bus.read_i) wbuf <= bus.line_i;
          end
        end
        RD_BURST: begin
          if (bus.resp_i) begin
            line_q[cnt] <= bus.burst_i;
            cnt         <= cnt + cw'(1);
          end
        end
        WR_BURST: begin
          if (bus.resp_i) cnt <= cnt + cw'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// Directed bench for p_cacheline_adaptor: reads, gapped reads, writes,
// priority, back-to-back requests and mid-burst reset.
module tb_p_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  p_cacheline_adaptor_if bus ();
  p_cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec     = 0;
  int n_miss    = 0;
  int resp_seen = 0;
  int r0;

  localparam logic [63:0] B1 = {16{4'h1}};
  localparam logic [63:0] B2 = {16{4'h2}};
  localparam logic [63:0] B3 = {16{4'h3}};
  localparam logic [63:0] B4 = {16{4'h4}};
  localparam logic [63:0] B5 = {16{4'h5}};
  localparam logic [63:0] B6 = {16{4'h6}};
  localparam logic [63:0] B7 = {16{4'h7}};
  localparam logic [63:0] B8 = {16{4'h8}};
  localparam logic [63:0] WA = {16{4'hA}};
  localparam logic [63:0] WB = {16{4'hB}};
  localparam logic [63:0] WC = {16{4'hC}};
  localparam logic [63:0] WD = {16{4'hD}};
  localparam logic [63:0] E1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] E2 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] E3 = 64'h0F0F_0F0F_F0F0_F0F0;
  localparam logic [63:0] E4 = 64'h1357_9BDF_2468_ACE0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.resp_o === 1'b1) resp_seen++;
  endtask

  task automatic rbeat(input logic [63:0] d, input string tag);
    chk({tag, "_read_o"}, bus.read_o, 1'b1);
    bus.resp_i  = 1'b1;
    bus.burst_i = d;
    tick();
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
  endtask

  task automatic wbeat(input logic [63:0] exp, input string tag);
    chk({tag, "_write_o"}, bus.write_o, 1'b1);
    chk({tag, "_burst_o"}, bus.burst_o, exp);
    bus.resp_i = 1'b1;
    tick();
    bus.resp_i = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_read_o",    bus.read_o,    1'b0);
    chk("rst_write_o",   bus.write_o,   1'b0);
    chk("rst_resp_o",    bus.resp_o,    1'b0);
    chk("rst_address_o", bus.address_o, 32'h0);
    chk("rst_line_o",    bus.line_o,    256'h0);
    chk("rst_burst_o",   bus.burst_o,   64'h0);

    // read, back-to-back beats
    bus.read_i    = 1'b1;
    bus.address_i = 32'h8000_0034;
    tick();
    chk("rd_address_o", bus.address_o, 32'h8000_0020);
    rbeat(B1, "rd0");
    rbeat(B2, "rd1");
    rbeat(B3, "rd2");
    chk("rd_no_early_resp", bus.resp_o, 1'b0);
    rbeat(B4, "rd3");
    chk("rd_resp_o",  bus.resp_o, 1'b1);
    chk("rd_read_lo", bus.read_o, 1'b0);
    chk("rd_line_o",  bus.line_o, {B4, B3, B2, B1});
    bus.read_i = 1'b0;
    tick();
    chk("rd_resp_single", bus.resp_o, 1'b0);
    chk("rd_idle_read_o", bus.read_o, 1'b0);

    // read with two idle cycles between beats 1 and 2
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0100;
    tick();
    chk("gap_address_o", bus.address_o, 32'h0000_0100);
    rbeat(B5, "gap0");
    rbeat(B6, "gap1");
    chk("gap_hold1_read_o", bus.read_o, 1'b1);
    tick();
    chk("gap_hold2_read_o", bus.read_o, 1'b1);
    tick();
    chk("gap_no_resp_c5", bus.resp_o, 1'b0);
    rbeat(B7, "gap2");
    chk("gap_no_resp_c6", bus.resp_o, 1'b0);
    rbeat(B8, "gap3");
    chk("gap_resp_o", bus.resp_o, 1'b1);
    chk("gap_line_o", bus.line_o, {B8, B7, B6, B5});
    bus.read_i = 1'b0;
    tick();

    // write with a gap after beat 0; line_i scrambled after accept
    bus.write_i   = 1'b1;
    bus.address_i = 32'h4000_001F;
    bus.line_i    = {WD, WC, WB, WA};
    tick();
    bus.line_i = '1;
    chk("wr_address_o", bus.address_o, 32'h4000_0000);
    chk("wr_no_read_o", bus.read_o, 1'b0);
    wbeat(WA, "wr0");
    chk("wr_gap_burst_o", bus.burst_o, WB);
    tick();
    wbeat(WB, "wr1");
    wbeat(WC, "wr2");
    chk("wr_no_early_resp", bus.resp_o, 1'b0);
    wbeat(WD, "wr3");
    chk("wr_resp_o",    bus.resp_o,  1'b1);
    chk("wr_write_lo",  bus.write_o, 1'b0);
    chk("wr_line_kept", bus.line_o,  {B8, B7, B6, B5});
    bus.write_i = 1'b0;
    tick();

    // resp_i in IDLE is ignored; read wins over simultaneous write
    bus.resp_i  = 1'b1;
    bus.burst_i = '1;
    tick();
    chk("ign_read_o",  bus.read_o,  1'b0);
    chk("ign_write_o", bus.write_o, 1'b0);
    tick();
    chk("ign_line_o",  bus.line_o,  {B8, B7, B6, B5});
    bus.resp_i    = 1'b0;
    bus.burst_i   = '0;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    bus.address_i = 32'h0000_2040;
    tick();
    chk("pri_read_o",    bus.read_o,    1'b1);
    chk("pri_write_o",   bus.write_o,   1'b0);
    chk("pri_address_o", bus.address_o, 32'h0000_2040);
    rbeat(E1, "pri0");
    rbeat(E2, "pri1");
    rbeat(E3, "pri2");
    rbeat(E4, "pri3");
    chk("pri_resp_o", bus.resp_o, 1'b1);
    chk("pri_line_o", bus.line_o, {E4, E3, E2, E1});
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    tick();

    // write then read presented the cycle after resp_o
    r0            = resp_seen;
    bus.write_i   = 1'b1;
    bus.address_i = 32'h3000_0040;
    bus.line_i    = {E1, E2, E3, E4};
    tick();
    wbeat(E4, "b2b_w0");
    wbeat(E3, "b2b_w1");
    wbeat(E2, "b2b_w2");
    wbeat(E1, "b2b_w3");
    chk("b2b_wr_resp_o", bus.resp_o, 1'b1);
    bus.write_i = 1'b0;
    tick();
    chk("b2b_gap_resp_o", bus.resp_o, 1'b0);
    bus.read_i    = 1'b1;
    bus.address_i = 32'h3000_0080;
    tick();
    chk("b2b_rd_accept", bus.read_o,    1'b1);
    chk("b2b_rd_addr",   bus.address_o, 32'h3000_0080);
    rbeat(B2, "b2b_r0");
    rbeat(B4, "b2b_r1");
    rbeat(B6, "b2b_r2");
    rbeat(B8, "b2b_r3");
    chk("b2b_rd_resp_o", bus.resp_o, 1'b1);
    chk("b2b_rd_line_o", bus.line_o, {B8, B6, B4, B2});
    bus.read_i = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b_resp_count", 32'(resp_seen - r0), 32'd2);

    // reset in the middle of a read burst
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_5000;
    tick();
    rbeat(WA, "mid0");
    rbeat(WB, "mid1");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_read_o",    bus.read_o,    1'b0);
    chk("mid_rst_write_o",   bus.write_o,   1'b0);
    chk("mid_rst_resp_o",    bus.resp_o,    1'b0);
    chk("mid_rst_address_o", bus.address_o, 32'h0);
    chk("mid_rst_line_o",    bus.line_o,    256'h0);
    chk("mid_rst_burst_o",   bus.burst_o,   64'h0);
    bus.read_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", bus.read_o, 1'b0);
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_1000;
    tick();
    chk("post_rst_addr", bus.address_o, 32'h0000_1000);
    rbeat(B1, "post0");
    rbeat(B3, "post1");
    rbeat(B5, "post2");
    chk("post_rst_no_early", bus.resp_o, 1'b0);
    rbeat(B7, "post3");
    chk("post_rst_resp_o", bus.resp_o, 1'b1);
    chk("post_rst_line_o", bus.line_o, {B7, B5, B3, B1});
    bus.read_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
